// File: rtl/floating_point_fma_issue.sv
// rtl/floating_point_fma_issue.sv - registered issue/retire stage around the combinational FMA datapath
// Stage-1 operand registers feed the datapath; results land in a 2-entry in-order FIFO with sticky flag accumulation.
module floating_point_fma_issue #(
  parameter int exp_width  = 8,
  parameter int frac_width = 23,
  parameter int tag_width  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [exp_width+frac_width:0] in_op1,
  input  logic [exp_width+frac_width:0] in_op2,
  input  logic [exp_width+frac_width:0] in_op_sum,
  input  logic [1:0]                    in_round_mode,
  input  logic                          in_use_dyn,
  input  logic [tag_width-1:0]          in_tag,
  input  logic [1:0]                    csr_round_mode,
  output logic [exp_width+frac_width:0] fma_op1,
  output logic [exp_width+frac_width:0] fma_op2,
  output logic [exp_width+frac_width:0] fma_op_sum,
  output logic [1:0]                    fma_round_mode,
  input  logic [exp_width+frac_width:0] fma_result,
  input  logic [4:0]                    fma_exception,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [exp_width+frac_width:0] out_result,
  output logic [4:0]                    out_exception,
  output logic [tag_width-1:0]          out_tag,
  input  logic                          flush,
  input  logic                          flags_clear,
  output logic [4:0]                    flags
);

  localparam int W  = exp_width + frac_width + 1;
  localparam int EW = W + 5 + tag_width;

  logic                 s1_valid_q, s1_valid_d;
  logic [W-1:0]         op1_q, op1_d;
  logic [W-1:0]         op2_q, op2_d;
  logic [W-1:0]         sum_q, sum_d;
  logic [1:0]           rm_q, rm_d;
  logic [tag_width-1:0] tag_q, tag_d;

  logic [EW-1:0]        mem_q [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;
  logic [4:0]           flags_q, flags_d;

  logic [1:0]           occupancy;
  logic                 in_fire;
  logic                 out_fire;
  logic                 push;
  logic [EW-1:0]        head;

  // Stage 1 always drains into the FIFO; the in_ready gate guarantees room.
  assign push      = s1_valid_q;
  assign head      = mem_q[rd_ptr_q];
  assign out_valid = (count_q != 2'd0);
  assign out_fire  = out_valid & out_ready;
  assign occupancy = {1'b0, s1_valid_q} + count_q;
  assign in_ready  = ~flush & ((occupancy < 2'd2) | out_fire);
  assign in_fire   = in_valid & in_ready;

  assign {out_result, out_exception, out_tag} = out_valid ? head : '0;

  assign fma_op1        = op1_q;
  assign fma_op2        = op2_q;
  assign fma_op_sum     = sum_q;
  assign fma_round_mode = rm_q;
  assign flags          = flags_q;

  always_comb begin
    s1_valid_d = in_fire;
    op1_d      = op1_q;
    op2_d      = op2_q;
    sum_d      = sum_q;
    rm_d       = rm_q;
    tag_d      = tag_q;
    if (in_fire) begin
      op1_d = in_op1;
      op2_d = in_op2;
      sum_d = in_op_sum;
      rm_d  = in_use_dyn ? csr_round_mode : in_round_mode;
      tag_d = in_tag;
    end

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push)     wr_ptr_d = ~wr_ptr_q;
      if (out_fire) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, out_fire};
    end

    // Clear first, then OR in the retiring entry; a flushed pop contributes nothing.
    flags_d = flags_q;
    if (flags_clear)         flags_d = '0;
    if (out_fire && !flush)  flags_d = flags_d | out_exception;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      sum_q      <= '0;
      rm_q       <= '0;
      tag_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      sum_q      <= sum_d;
      rm_q       <= rm_d;
      tag_q      <= tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      flags_q    <= flags_d;
    end
  end

  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {fma_result, fma_exception, tag_q};
  end

endmodule

// File: tb/tb_floating_point_fma_issue.sv
// tb/tb_floating_point_fma_issue.sv - scoreboard bench for floating_point_fma_issue
// A small single-precision multiply model stands in for the datapath (normal operands, op_sum = +0 only).
module tb_floating_point_fma_issue;

  localparam logic [1:0] RNE = 2'd0;
  localparam logic [1:0] RTZ = 2'd1;
  localparam logic [4:0] OF_NX = 5'b00101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_op1 = '0, in_op2 = '0, in_op_sum = '0;
  logic [1:0]  in_round_mode = '0;
  logic        in_use_dyn = 1'b0;
  logic [3:0]  in_tag = '0;
  logic [1:0]  csr_round_mode = '0;
  logic [31:0] fma_op1, fma_op2, fma_op_sum;
  logic [1:0]  fma_round_mode;
  logic [31:0] fma_result;
  logic [4:0]  fma_exception;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_exception;
  logic [3:0]  out_tag;
  logic        flush = 1'b0;
  logic        flags_clear = 1'b0;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_fail = 0;
  logic [40:0] exp_q [$];

  always #5 clk = ~clk;

  floating_point_fma_issue #(.exp_width(8), .frac_width(23), .tag_width(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_op_sum(in_op_sum),
    .in_round_mode(in_round_mode), .in_use_dyn(in_use_dyn), .in_tag(in_tag),
    .csr_round_mode(csr_round_mode),
    .fma_op1(fma_op1), .fma_op2(fma_op2), .fma_op_sum(fma_op_sum),
    .fma_round_mode(fma_round_mode),
    .fma_result(fma_result), .fma_exception(fma_exception),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exception(out_exception), .out_tag(out_tag),
    .flush(flush), .flags_clear(flags_clear), .flags(flags)
  );

  function automatic logic [36:0] fp_mul(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [1:0] rm);
    logic [47:0] prod;
    logic [22:0] m;
    logic [23:0] rest;
    logic [23:0] mr;
    logic        s, rnd, stk, inc, to_max;
    int          e;
    if (c[30:0] != 31'd0) return {32'h7FC00000, 5'b10000};
    s    = a[31] ^ b[31];
    prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e    = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (prod[47]) begin
      m = prod[46:24]; rest = prod[23:0]; e = e + 1;
    end else begin
      m = prod[45:23]; rest = {prod[22:0], 1'b0};
    end
    rnd = rest[23];
    stk = |rest[22:0];
    case (rm)
      2'd0:    inc = rnd & (stk | m[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = s & (rnd | stk);
      default: inc = ~s & (rnd | stk);
    endcase
    mr = {1'b0, m} + 24'(inc);
    if (mr[23]) begin m = '0; e = e + 1; end else m = mr[22:0];
    if (e >= 255) begin
      to_max = (rm == 2'd1) || (rm == 2'd2 && !s) || (rm == 2'd3 && s);
      return to_max ? {s, 8'hFE, 23'h7FFFFF, OF_NX} : {s, 8'hFF, 23'h0, OF_NX};
    end
    return {s, e[7:0], m, (rnd | stk) ? 5'b00001 : 5'b00000};
  endfunction

  always_comb {fma_result, fma_exception} = fp_mul(fma_op1, fma_op2, fma_op_sum, fma_round_mode);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every real retirement.
  initial begin
    logic [40:0] e;
    forever begin
      @(negedge clk);
      if (!reset && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: got tag %0h result %0h expected nothing", out_tag, out_result);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("retire_tag%0h", e[3:0]), 64'({out_result, out_exception, out_tag}), 64'(e));
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm,
                       input logic dyn, input logic [3:0] tag,
                       input logic [31:0] er, input logic [4:0] ee);
    logic got = 1'b0;
    in_op1 = a; in_op2 = b; in_op_sum = '0; in_round_mode = rm;
    in_use_dyn = dyn; in_tag = tag; in_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({er, ee, tag});
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check($sformatf("issue_accept_tag%0h", tag), 64'(got), 64'd1);
  endtask

  task automatic drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 50) begin
      @(posedge clk); i++;
    end
    repeat (2) @(posedge clk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic pulse_clear();
    flags_clear = 1'b1;
    @(posedge clk); #1;
    flags_clear = 1'b0;
  endtask

  function automatic logic [31:0] val(input int k);
    return 32'h3F800000 + 32'(k << 16);
  endfunction

  initial begin
    int acc, nxt, stalls, k, cyc;
    logic fired;

    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    check("rst_fma_ops", 64'({fma_op1, fma_op2}), 64'd0);
    check("rst_fma_sum_rm", 64'({fma_op_sum, fma_round_mode}), 64'd0);
    check("rst_out_fields", 64'({out_result, out_exception, out_tag}), 64'd0);

    // Single op with latency probe.
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_op1 = 32'h3F800000; in_op2 = 32'h40000000; in_op_sum = '0;
    in_round_mode = RNE; in_use_dyn = 1'b0; in_tag = 4'd5; in_valid = 1'b1;
    @(negedge clk);
    check("single_in_ready", 64'(in_ready), 64'd1);
    exp_q.push_back({32'h40000000, 5'd0, 4'd5});
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("single_fma_ops", 64'({fma_op1, fma_op2}), {32'h3F800000, 32'h40000000});
    check("single_n1_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("single_n2_out_valid", 64'(out_valid), 64'd1);
    drain("single_drain");
    check("single_flags", 64'(flags), 64'd0);

    // Overflow then a clean op: the overflow flag must stick.
    issue(32'h7F000000, 32'h7F000000, RNE, 1'b0, 4'd6, 32'h7F800000, OF_NX);
    issue(32'h3F800000, 32'h40400000, RNE, 1'b0, 4'd7, 32'h40400000, 5'd0);
    drain("ovf_drain");
    check("ovf_flags_sticky", 64'(flags), 64'(OF_NX));
    pulse_clear();
    @(negedge clk);
    check("flags_after_clear", 64'(flags), 64'd0);

    // Backpressure: only two accepted while the consumer stalls.
    @(posedge clk); #1;
    out_ready = 1'b0; acc = 0; nxt = 1;
    in_op1 = 32'h3F800000; in_round_mode = RNE; in_use_dyn = 1'b0; in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      in_tag = 4'(nxt); in_op2 = val(nxt);
      @(negedge clk);
      fired = 1'b0;
      if (in_ready) begin
        exp_q.push_back({val(nxt), 5'd0, 4'(nxt)});
        fired = 1'b1;
      end
      @(posedge clk); #1;
      if (fired) begin nxt++; acc++; end
    end
    in_valid = 1'b0;
    check("bp_accepted", 64'(acc), 64'd2);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_head_held", 64'({out_valid, out_tag, out_result}), {27'd0, 1'b1, 4'd1, val(1)});
    out_ready = 1'b1;
    issue(32'h3F800000, val(3), RNE, 1'b0, 4'd3, val(3), 5'd0);
    issue(32'h3F800000, val(4), RNE, 1'b0, 4'd4, val(4), 5'd0);
    drain("bp_drain");

    // Dynamic rounding mode captured at acceptance.
    csr_round_mode = RTZ;
    issue(32'h7F000000, 32'h7F000000, RNE, 1'b1, 4'd9, 32'h7F7FFFFF, OF_NX);
    csr_round_mode = RNE;
    @(negedge clk);
    check("dyn_fma_round_mode", 64'(fma_round_mode), 64'(RTZ));
    drain("dyn_drain");
    pulse_clear();

    // Flush with one entry queued and stage 1 busy; head carries overflow flags.
    out_ready = 1'b0;
    issue(32'h7F000000, 32'h7F000000, RNE, 1'b0, 4'd8, 32'h7F800000, OF_NX);
    issue(32'h3F800000, val(9), RNE, 1'b0, 4'd9, val(9), 5'd0);
    flush = 1'b1; out_ready = 1'b1;
    in_op1 = 32'h3F800000; in_op2 = val(10); in_tag = 4'd10; in_valid = 1'b1;
    @(negedge clk);
    check("flush_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_flags", 64'(flags), 64'd0);
    repeat (2) @(negedge clk);
    check("flush_stays_empty", 64'(out_valid), 64'd0);

    // Full-rate streaming.
    @(posedge clk); #1;
    k = 0; stalls = 0; cyc = 0;
    in_op1 = 32'h3F800000; in_round_mode = RNE; in_use_dyn = 1'b0; in_valid = 1'b1;
    while (k < 100 && cyc < 400) begin
      in_op2 = val(k); in_tag = 4'(k);
      @(negedge clk);
      fired = 1'b0;
      if (in_ready) begin
        exp_q.push_back({val(k), 5'd0, 4'(k)});
        fired = 1'b1;
      end else stalls++;
      @(posedge clk); #1;
      if (fired) k++;
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", 64'(k), 64'd100);
    check("stream_no_stall", 64'(stalls), 64'd0);
    drain("stream_drain");

    // Overflow stream, then reset while requests are still arriving.
    k = 0; cyc = 0;
    in_op1 = 32'h7F000000; in_op2 = 32'h7F000000; in_valid = 1'b1;
    while (k < 6 && cyc < 40) begin
      in_tag = 4'(k);
      @(negedge clk);
      fired = 1'b0;
      if (in_ready) begin
        exp_q.push_back({32'h7F800000, OF_NX, 4'(k)});
        fired = 1'b1;
      end
      @(posedge clk); #1;
      if (fired) k++;
      cyc++;
    end
    @(negedge clk);
    check("pre_reset_flags", 64'(flags), 64'(OF_NX));
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_flags", 64'(flags), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (3) @(negedge clk);
    check("midrst_stays_empty", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
